countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counting timer with terminal-count signalling, pause and optional auto-reload. It is the decrementing counterpart of the team's loadable up-counter: software or a controlling FSM loads a start value and gets a one-cycle `done` pulse when the count reaches zero. It sits beside the up-counter in the training datapath and generates timeouts and periodic ticks.

## Interface
- `WIDTH`, default 5, bit width of `data`, `count` and the internal reload register.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset; highest priority.
- `data`  input  WIDTH  start/reload value, sampled when `load` = 1.
- `load`  input  1  capture `data` into `count` and into the reload register, then start.
- `pause`  input  1  while in RUN, hold `count` unchanged.
- `auto_reload`  input  1  at terminal count, restart from the reload register instead of stopping; sampled on the terminal edge.
- `count`  output  WIDTH  current count value (registered).
- `busy`  output  1  high while in RUN (registered).
- `done`  output  1  one-cycle terminal-count pulse (registered).

## Operation
- The FSM has two states, IDLE and RUN. `busy` equals (state == RUN).
- Reset (`rst` = 1 at an edge) applies in any state and wins over everything else:
  - state IDLE, `count` = 0, reload register = 0, `busy` = 0, `done` = 0.
- Priority per edge: `rst` > `load` > terminal-count/decrement > `pause` hold.
- `load` in any state:
  - `count` <= `data` and reload register <= `data`.
  - If `data` != 0, the next state is RUN.
  - If `data` == 0, the next state is IDLE and `done` is not pulsed.
  - `load` during RUN restarts the timer with the new value. It does not generate `done`.
- RUN with `pause` = 0 and `count` > 1: `count` <= `count` − 1.
- RUN with `pause` = 0 and `count` == 1 (terminal edge): `done` <= 1.
  - If `auto_reload` = 1: `count` <= reload register and the state stays RUN.
  - If `auto_reload` = 0: `count` <= 0 and the next state is IDLE.
- RUN with `pause` = 1: `count`, state and reload register hold, and `done` <= 0. `pause` is ignored in IDLE.
- IDLE without `load`: everything holds. `count` stays at its last value (0 after a natural finish).
- `done` is 0 on every edge other than a terminal edge. It is never high for two consecutive cycles unless the reload value is 1 with `auto_reload` = 1, in which case `done` is high every cycle.
- Arithmetic is unsigned, modulo 2^WIDTH. `count` never decrements below 0 and never wraps; a terminal edge always handles the 1 → 0 transition.
- All values 1 .. 2^WIDTH−1 are legal. The maximum value 31 (WIDTH = 5) counts the full range.

## Timing
- Load at edge L (with `data` = D != 0):
  - `count` = D and `busy` = 1 are visible after edge L.
  - The first decrement happens at edge L+1.
- With no pause, the terminal edge is L+D. After it, `done` = 1 for one cycle and `count` = 0 (or D if auto-reloading).
- Each paused cycle adds exactly one cycle to that latency.
- Auto-reload period: `done` pulses every D cycles, with no gap cycle at reload.
- `pause` asserted on the terminal edge suppresses it. Termination occurs on the first later edge with `pause` = 0.
- `load` on the terminal edge wins: no `done`, and `count` = new `data`.
- `rst` mid-run takes effect on that edge; outputs are 0 after it, with no `done`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: drive `rst` = 1 for 2 cycles during RUN (`count` = 7) → `count` = 0, `busy` = 0, `done` = 0 after the first reset edge, and they remain so until `load`.
- Basic countdown: load 5, no pause → `count` reads 5, 4, 3, 2, 1, 0 on successive cycles; `done` = 1 only in the cycle `count` = 0; `busy` drops in that same cycle.
- Pause: load 4, hold `pause` = 1 for 3 cycles when `count` = 2 → `count` holds at 2 for 3 cycles, and `done` arrives 3 cycles later than unpaused (7 cycles after load).
- Auto-reload: load 3 with `auto_reload` = 1 for 10 cycles → `done` pulses exactly every 3 cycles and `count` cycles 3, 2, 1, 3, 2, 1 …; deasserting `auto_reload` before the next terminal edge → `count` ends at 0 and `busy` = 0.
- Mid-run reload and zero load:
  - Load 31, then load 2 when `count` = 20 → `count` reads 2, 1, 0 with exactly one `done`.
  - Load 0 → `busy` stays 0 and `done` never asserts.
- Boundary collisions:
  - `load` = 1 (`data` = 9) on the terminal edge → no `done`, and `count` = 9.
  - `rst` on the terminal edge → no `done`, and `count` = 0.

Source files
------------

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Loadable down-counting timer with a one-cycle terminal-count pulse, pause
// and optional auto-reload. A controller loads a start value and the timer
// counts it down to zero, pulsing `done` on the edge that takes the count
// from 1 to 0. With auto-reload it restarts from the last loaded value
// instead. This gives a periodic tick every D cycles, with no gap cycle.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset, highest priority
//   data         start/reload value, sampled when load = 1
//   load         capture data into count and reload register, start if != 0
//   pause        while running, hold the count (ignored when idle)
//   auto_reload  on the terminal edge, restart from the reload register
//   count        current count value (registered)
//   busy         high while in RUN (decoded from the state register)
//   done         one-cycle terminal-count pulse (registered)
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] reload_q;

  // busy is a pure decode of the state flop, so it is as registered as the
  // state itself and has no path from any input.
  assign busy = (state == S_RUN);

  // Priority per edge: rst > load > terminal/decrement > pause hold.
  // NOTE: every register in this block is assigned with <= so all of them
  // update together from the values that existed before the edge. A blocking
  // assignment here would let later statements see half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      reload_q <= '0;
      done     <= 1'b0;
    end else begin
      // The pulse defaults low and is raised only on a terminal edge.
      done <= 1'b0;

      if (load) begin
        // A load restarts the timer and never produces done, even when it
        // lands on what would have been the terminal edge.
        count    <= data;
        reload_q <= data;
        state    <= (data != '0) ? S_RUN : S_IDLE;
      end else if (state == S_RUN && !pause) begin
        if (count == ONE) begin
          // Terminal edge: the 1 -> 0 step is handled here, so the
          // counter never decrements through zero.
          done <= 1'b1;
          if (auto_reload) begin
            count <= reload_q;
          end else begin
            count <= '0;
            state <= S_IDLE;
          end
        end else if (count == '0) begin
          // Unreachable in normal use (RUN is only entered with a nonzero
          // value). Drop back to IDLE rather than wrapping.
          state <= S_IDLE;
        end else begin
          count <= count - ONE;
        end
      end
      // RUN with pause, or IDLE without load: everything holds.
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//
// Self-checking bench for countdown_timer (WIDTH = 5). Each stimulus record
// carries the inputs for one clock edge and the outputs expected after that
// edge. The expected part is pushed to a scoreboard queue when the inputs are
// driven. It is popped and compared 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int WIDTH = 5;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] data;
  logic             load;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .load        (load),
    .pause       (pause),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             pause;
    logic             ar;
    logic [WIDTH-1:0] ecount;
    logic             ebusy;
    logic             edone;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(string tag, bit r, bit l, int d, bit p, bit a,
                              int c, bit b, bit dn);
    vec_t v;
    v.tag    = tag;
    v.rst    = r;
    v.load   = l;
    v.data   = WIDTH'(d);
    v.pause  = p;
    v.ar     = a;
    v.ecount = WIDTH'(c);
    v.ebusy  = b;
    v.edone  = dn;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one record, clock it and compare against the scoreboard head.
  task automatic step(input vec_t v);
    vec_t e;
    sb.push_back(v);
    rst         = v.rst;
    load        = v.load;
    data        = v.data;
    pause       = v.pause;
    auto_reload = v.ar;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "/count"}, int'(count), int'(e.ecount));
    check({e.tag, "/busy"},  int'(busy),  int'(e.ebusy));
    check({e.tag, "/done"},  int'(done),  int'(e.edone));
  endtask

  // Hard time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load = 1'b0; data = '0; pause = 1'b0; auto_reload = 1'b0;

    //            tag          rst ld dat ps ar  cnt bsy dn
    // Reset during RUN (count = 7), held two cycles, then stays cleared.
    tbl.push_back(mk("rst0",    1, 0,  0, 0, 0,   0, 0, 0));
    tbl.push_back(mk("rst_ld7", 0, 1,  7, 0, 0,   7, 1, 0));
    tbl.push_back(mk("rst_a",   1, 0,  0, 0, 0,   0, 0, 0));
    tbl.push_back(mk("rst_b",   1, 0,  0, 0, 0,   0, 0, 0));
    tbl.push_back(mk("rst_h1",  0, 0,  0, 0, 0,   0, 0, 0));
    tbl.push_back(mk("rst_h2",  0, 0,  0, 1, 0,   0, 0, 0));
    // Basic countdown from 5.
    tbl.push_back(mk("bas_ld",  0, 1,  5, 0, 0,   5, 1, 0));
    tbl.push_back(mk("bas_4",   0, 0,  0, 0, 0,   4, 1, 0));
    tbl.push_back(mk("bas_3",   0, 0,  0, 0, 0,   3, 1, 0));
    tbl.push_back(mk("bas_2",   0, 0,  0, 0, 0,   2, 1, 0));
    tbl.push_back(mk("bas_1",   0, 0,  0, 0, 0,   1, 1, 0));
    tbl.push_back(mk("bas_0",   0, 0,  0, 0, 0,   0, 0, 1));
    tbl.push_back(mk("bas_idl", 0, 0,  0, 0, 0,   0, 0, 0));
    // Pause for 3 cycles at count 2: done 7 cycles after load.
    tbl.push_back(mk("pau_ld",  0, 1,  4, 0, 0,   4, 1, 0));
    tbl.push_back(mk("pau_3",   0, 0,  0, 0, 0,   3, 1, 0));
    tbl.push_back(mk("pau_2",   0, 0,  0, 0, 0,   2, 1, 0));
    tbl.push_back(mk("pau_h1",  0, 0,  0, 1, 0,   2, 1, 0));
    tbl.push_back(mk("pau_h2",  0, 0,  0, 1, 0,   2, 1, 0));
    tbl.push_back(mk("pau_h3",  0, 0,  0, 1, 0,   2, 1, 0));
    tbl.push_back(mk("pau_1",   0, 0,  0, 0, 0,   1, 1, 0));
    tbl.push_back(mk("pau_0",   0, 0,  0, 0, 0,   0, 0, 1));
    // Auto-reload of 3 for 10 cycles, then let it run out.
    tbl.push_back(mk("ar_ld",   0, 1,  3, 0, 1,   3, 1, 0));
    tbl.push_back(mk("ar_2a",   0, 0,  0, 0, 1,   2, 1, 0));
    tbl.push_back(mk("ar_1a",   0, 0,  0, 0, 1,   1, 1, 0));
    tbl.push_back(mk("ar_t1",   0, 0,  0, 0, 1,   3, 1, 1));
    tbl.push_back(mk("ar_2b",   0, 0,  0, 0, 1,   2, 1, 0));
    tbl.push_back(mk("ar_1b",   0, 0,  0, 0, 1,   1, 1, 0));
    tbl.push_back(mk("ar_t2",   0, 0,  0, 0, 1,   3, 1, 1));
    tbl.push_back(mk("ar_2c",   0, 0,  0, 0, 1,   2, 1, 0));
    tbl.push_back(mk("ar_1c",   0, 0,  0, 0, 1,   1, 1, 0));
    tbl.push_back(mk("ar_t3",   0, 0,  0, 0, 1,   3, 1, 1));
    tbl.push_back(mk("ar_off2", 0, 0,  0, 0, 0,   2, 1, 0));
    tbl.push_back(mk("ar_off1", 0, 0,  0, 0, 0,   1, 1, 0));
    tbl.push_back(mk("ar_end",  0, 0,  0, 0, 0,   0, 0, 1));
    tbl.push_back(mk("ar_idl",  0, 0,  0, 0, 0,   0, 0, 0));
    // Zero load: from IDLE and in the middle of a run.
    tbl.push_back(mk("z_ld0",   0, 1,  0, 0, 0,   0, 0, 0));
    tbl.push_back(mk("z_idl",   0, 0,  0, 0, 0,   0, 0, 0));
    tbl.push_back(mk("z_ld5",   0, 1,  5, 0, 0,   5, 1, 0));
    tbl.push_back(mk("z_run0",  0, 1,  0, 0, 0,   0, 0, 0));
    tbl.push_back(mk("z_idl2",  0, 0,  0, 0, 0,   0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Mid-run reload: load 31, reload 2 at count 20, exactly one done.
    step(mk("mid_ld31", 0, 1, 31, 0, 0, 31, 1, 0));
    for (int i = 30; i >= 20; i--) step(mk("mid_dec", 0, 0, 0, 0, 0, i, 1, 0));
    step(mk("mid_ld2",  0, 1,  2, 0, 0,  2, 1, 0));
    step(mk("mid_1",    0, 0,  0, 0, 0,  1, 1, 0));
    step(mk("mid_0",    0, 0,  0, 0, 0,  0, 0, 1));
    step(mk("mid_idl",  0, 0,  0, 0, 0,  0, 0, 0));

    // Full range from the maximum value 31.
    step(mk("full_ld",  0, 1, 31, 0, 0, 31, 1, 0));
    for (int i = 30; i >= 1; i--) step(mk("full_dec", 0, 0, 0, 0, 0, i, 1, 0));
    step(mk("full_0",   0, 0,  0, 0, 0,  0, 0, 1));

    // Load on the terminal edge wins: no done, count = 9.
    step(mk("lt_ld2",   0, 1,  2, 0, 0,  2, 1, 0));
    step(mk("lt_1",     0, 0,  0, 0, 0,  1, 1, 0));
    step(mk("lt_ld9",   0, 1,  9, 0, 0,  9, 1, 0));
    step(mk("lt_8",     0, 0,  0, 0, 0,  8, 1, 0));

    // Reset on the terminal edge: no done, count = 0.
    step(mk("rt_ld1",   0, 1,  1, 0, 0,  1, 1, 0));
    step(mk("rt_rst",   1, 0,  0, 0, 0,  0, 0, 0));
    step(mk("rt_idl",   0, 0,  0, 0, 0,  0, 0, 0));

    // Pause on the terminal edge defers termination.
    step(mk("pt_ld2",   0, 1,  2, 0, 0,  2, 1, 0));
    step(mk("pt_1",     0, 0,  0, 0, 0,  1, 1, 0));
    step(mk("pt_h1",    0, 0,  0, 1, 0,  1, 1, 0));
    step(mk("pt_h2",    0, 0,  0, 1, 0,  1, 1, 0));
    step(mk("pt_0",     0, 0,  0, 0, 0,  0, 0, 1));

    // Reload value 1 with auto-reload: done every cycle.
    step(mk("r1_ld",    0, 1,  1, 0, 1,  1, 1, 0));
    step(mk("r1_t1",    0, 0,  0, 0, 1,  1, 1, 1));
    step(mk("r1_t2",    0, 0,  0, 0, 1,  1, 1, 1));
    step(mk("r1_end",   0, 0,  0, 0, 0,  0, 0, 1));
    step(mk("r1_idl",   0, 0,  0, 0, 0,  0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
